// File: rtl/map_table.sv
// map_table: rename map table for a 3-wide dispatch group, with intra-group bypass and CDB ready tracking.
// Optional MAP_TABLE_CDB_BYPASS_EN: table hits whose tag is on the CDB this cycle report ready immediately.
module map_table #(
    parameter  int SIZE     = 32,
    parameter  int ROB_SIZE = 32,
    localparam int RW       = $clog2(SIZE),
    localparam int TW       = $clog2(ROB_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_en,
    input  logic [2:0][RW-1:0]    source_reg_idx_in1,
    input  logic [2:0][RW-1:0]    source_reg_idx_in2,
    input  logic [2:0][RW-1:0]    dest_reg_idx_in,
    input  logic [1:0]            rob_dispatch_num,
    input  logic [TW-1:0]         rob_tail_in,
    input  logic                  complete_en,
    input  logic [2:0][TW-1:0]    CDB_tag_in,
    input  logic [1:0]            rob_complete_num,
    output logic [2:0][TW-1:0]    tag_out1,
    output logic [2:0][TW-1:0]    tag_out2,
    output logic [2:0]            ready_out1,
    output logic [2:0]            ready_out2,
    output logic [2:0]            hit1,
    output logic [2:0]            hit2,
    output logic [SIZE-1:0]       check_ready
);
    logic [SIZE-1:0]          r_valid;
    logic [SIZE-1:0]          r_ready;
    logic [SIZE-1:0][TW-1:0]  r_tag;
    logic [2:0]               w_slot_valid;
    logic [2:0]               w_cdb_valid;
    logic [2:0][TW-1:0]       w_slot_tag;
    logic [1:0][2:0][RW-1:0]  w_src;
    logic [1:0][2:0]          w_hit;
    logic [1:0][2:0]          w_rdy;
    logic [1:0][2:0][TW-1:0]  w_tag;

    assign w_slot_valid = !dispatch_en ? 3'b000 : rob_dispatch_num == 2'd3 ? 3'b111 :
                          rob_dispatch_num == 2'd2 ? 3'b011 : rob_dispatch_num == 2'd1 ? 3'b001 : 3'b000;
    assign w_cdb_valid  = !complete_en ? 3'b000 : rob_complete_num == 2'd3 ? 3'b111 :
                          rob_complete_num == 2'd2 ? 3'b011 : rob_complete_num == 2'd1 ? 3'b001 : 3'b000;
    assign w_src        = {source_reg_idx_in2, source_reg_idx_in1};

    // The group occupies the last num ROB entries ending at the tail.
    for (genvar i = 0; i < 3; i++) begin : g_slot
        assign w_slot_tag[i] = rob_tail_in - TW'(rob_dispatch_num) + TW'(i + 1);
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) begin
                w_hit[s][i] = r_valid[w_src[s][i]];
                w_tag[s][i] = w_hit[s][i] ? r_tag[w_src[s][i]] : '0;
                w_rdy[s][i] = w_hit[s][i] & r_ready[w_src[s][i]];
`ifdef MAP_TABLE_CDB_BYPASS_EN
                for (int k = 0; k < 3; k++)
                    if (w_hit[s][i] && w_cdb_valid[k] && CDB_tag_in[k] == w_tag[s][i]) w_rdy[s][i] = 1'b1;
`endif
                // Later j overrides, so the youngest older producer in the group wins.
                for (int j = 0; j < i; j++) begin
                    if (w_slot_valid[j] && w_src[s][i] != '0 && dest_reg_idx_in[j] == w_src[s][i]) begin
                        w_hit[s][i] = 1'b1;
                        w_tag[s][i] = w_slot_tag[j];
                        w_rdy[s][i] = 1'b0;
                    end
                end
            end
        end
    end

    assign hit1        = w_hit[0];
    assign hit2        = w_hit[1];
    assign tag_out1    = w_tag[0];
    assign tag_out2    = w_tag[1];
    assign ready_out1  = w_rdy[0];
    assign ready_out2  = w_rdy[1];
    assign check_ready = r_ready & r_valid;

    // Dispatch writes come after completion so a same-cycle remap clears ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_ready <= '0;
            r_tag   <= '0;
        end else begin
            for (int r = 1; r < SIZE; r++)
                for (int k = 0; k < 3; k++)
                    if (r_valid[r] && w_cdb_valid[k] && r_tag[r] == CDB_tag_in[k]) r_ready[r] <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (w_slot_valid[i] && dest_reg_idx_in[i] != '0) begin
                    r_valid[dest_reg_idx_in[i]] <= 1'b1;
                    r_tag[dest_reg_idx_in[i]]   <= w_slot_tag[i];
                    r_ready[dest_reg_idx_in[i]] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_map_table.sv
// tb_map_table: table-driven cycle-by-cycle vectors for map_table plus hand-written reset sequences.
module tb_map_table;
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             dispatch_en = 1'b0;
    logic [2:0][4:0]  source_reg_idx_in1 = '0;
    logic [2:0][4:0]  source_reg_idx_in2 = '0;
    logic [2:0][4:0]  dest_reg_idx_in = '0;
    logic [1:0]       rob_dispatch_num = '0;
    logic [4:0]       rob_tail_in = '0;
    logic             complete_en = 1'b0;
    logic [2:0][4:0]  CDB_tag_in = '0;
    logic [1:0]       rob_complete_num = '0;
    logic [2:0][4:0]  tag_out1, tag_out2;
    logic [2:0]       ready_out1, ready_out2, hit1, hit2;
    logic [31:0]      check_ready;

    int checks = 0;
    int failures = 0;
    int vi = 0;

    map_table dut (
        .clk(clk), .reset(reset), .dispatch_en(dispatch_en),
        .source_reg_idx_in1(source_reg_idx_in1), .source_reg_idx_in2(source_reg_idx_in2),
        .dest_reg_idx_in(dest_reg_idx_in), .rob_dispatch_num(rob_dispatch_num),
        .rob_tail_in(rob_tail_in), .complete_en(complete_en), .CDB_tag_in(CDB_tag_in),
        .rob_complete_num(rob_complete_num), .tag_out1(tag_out1), .tag_out2(tag_out2),
        .ready_out1(ready_out1), .ready_out2(ready_out2), .hit1(hit1), .hit2(hit2),
        .check_ready(check_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            de;
        logic [1:0]      dn;
        logic [4:0]      tail;
        logic [2:0][4:0] rd, s1, s2;
        logic            ce;
        logic [1:0]      cn;
        logic [2:0][4:0] cdb;
        logic [2:0]      h1;
        logic [2:0][4:0] t1;
        logic [2:0]      r1;
        logic [2:0]      h2;
        logic [2:0][4:0] t2;
        logic [2:0]      r2;
        logic [31:0]     cr;
    } vec_t;

    localparam logic [14:0] Z = '0;
    vec_t v [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec%0d got=%h exp=%h", name, vi, act, exp);
        end
    endtask

    initial begin
        //          de dn tail rd                  s1                  s2                  ce cn cdb                 h1      t1                     r1      h2      t2                     r2      cr
        v[0]  = '{0, 0, 0,  Z,                  {5'd1,5'd2,5'd0},   {5'd2,5'd0,5'd1},   0, 0, Z,                  3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h0};
        v[1]  = '{1, 2, 5,  {5'd3,5'd2,5'd1},   {5'd0,5'd0,5'd1},   {5'd0,5'd0,5'd2},   0, 0, Z,                  3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h0};
        v[2]  = '{0, 0, 0,  Z,                  {5'd0,5'd0,5'd1},   {5'd0,5'd3,5'd2},   0, 0, Z,                  3'b001, {5'd0,5'd0,5'd4},      3'b000, 3'b001, {5'd0,5'd0,5'd5},      3'b000, 32'h0};
        v[3]  = '{0, 0, 0,  Z,                  Z,                  Z,                  1, 1, {5'd0,5'd4,5'd5},   3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h0};
        v[4]  = '{0, 0, 0,  Z,                  {5'd0,5'd0,5'd2},   {5'd0,5'd0,5'd1},   0, 0, Z,                  3'b001, {5'd0,5'd0,5'd5},      3'b001, 3'b001, {5'd0,5'd0,5'd4},      3'b000, 32'h4};
        v[5]  = '{1, 2, 9,  {5'd0,5'd0,5'd4},   {5'd0,5'd4,5'd4},   {5'd0,5'd2,5'd0},   0, 0, Z,                  3'b010, {5'd0,5'd8,5'd0},      3'b000, 3'b010, {5'd0,5'd5,5'd0},      3'b010, 32'h4};
        v[6]  = '{1, 1, 12, {5'd0,5'd0,5'd2},   Z,                  Z,                  1, 2, {5'd0,5'd8,5'd5},   3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h4};
        v[7]  = '{0, 0, 0,  Z,                  {5'd0,5'd1,5'd2},   {5'd0,5'd3,5'd4},   0, 0, Z,                  3'b011, {5'd0,5'd4,5'd12},     3'b000, 3'b001, {5'd0,5'd0,5'd8},      3'b001, 32'h10};
        v[8]  = '{1, 3, 0,  {5'd7,5'd6,5'd5},   {5'd5,5'd5,5'd0},   {5'd6,5'd0,5'd0},   0, 0, Z,                  3'b110, {5'd30,5'd30,5'd0},    3'b000, 3'b100, {5'd31,5'd0,5'd0},     3'b000, 32'h10};
        v[9]  = '{0, 0, 0,  Z,                  {5'd0,5'd7,5'd5},   {5'd4,5'd3,5'd6},   0, 0, Z,                  3'b011, {5'd0,5'd0,5'd30},     3'b000, 3'b101, {5'd8,5'd0,5'd31},     3'b100, 32'h10};
        v[10] = '{1, 3, 20, {5'd9,5'd9,5'd9},   {5'd9,5'd9,5'd9},   Z,                  1, 0, Z,                  3'b110, {5'd19,5'd18,5'd0},    3'b000, 3'b000, Z,                     3'b000, 32'h10};
        v[11] = '{0, 0, 0,  Z,                  {5'd0,5'd0,5'd9},   {5'd0,5'd0,5'd7},   0, 0, Z,                  3'b001, {5'd0,5'd0,5'd20},     3'b000, 3'b001, Z,                     3'b000, 32'h10};
        v[12] = '{0, 0, 0,  Z,                  Z,                  Z,                  0, 1, {5'd0,5'd0,5'd20},  3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h10};
        v[13] = '{0, 0, 0,  Z,                  Z,                  Z,                  1, 3, {5'd20,5'd0,5'd31}, 3'b000, Z,                     3'b000, 3'b000, Z,                     3'b000, 32'h10};
        v[14] = '{0, 0, 0,  Z,                  {5'd0,5'd0,5'd6},   {5'd0,5'd0,5'd5},   0, 0, Z,                  3'b001, {5'd0,5'd0,5'd31},     3'b001, 3'b001, {5'd0,5'd0,5'd30},     3'b000, 32'h2D0};

        repeat (2) @(negedge clk);
        chk("reset_cr", check_ready, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vi = i;
            dispatch_en = v[i].de; rob_dispatch_num = v[i].dn; rob_tail_in = v[i].tail;
            dest_reg_idx_in = v[i].rd; source_reg_idx_in1 = v[i].s1; source_reg_idx_in2 = v[i].s2;
            complete_en = v[i].ce; rob_complete_num = v[i].cn; CDB_tag_in = v[i].cdb;
            #1;
            chk("hit1", 32'(hit1), 32'(v[i].h1));
            chk("tag1", 32'(tag_out1), 32'(v[i].t1));
            chk("rdy1", 32'(ready_out1), 32'(v[i].r1));
            chk("hit2", 32'(hit2), 32'(v[i].h2));
            chk("tag2", 32'(tag_out2), 32'(v[i].t2));
            chk("rdy2", 32'(ready_out2), 32'(v[i].r2));
            chk("check_ready", check_ready, v[i].cr);
        end

        // Asynchronous reset mid-cycle clears the table immediately.
        @(negedge clk);
        vi = 100;
        dispatch_en = 0; complete_en = 0;
        source_reg_idx_in1 = {5'd0, 5'd0, 5'd6};
        source_reg_idx_in2 = {5'd0, 5'd0, 5'd9};
        #1;
        chk("pre_async_hit1", 32'(hit1), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_cr", check_ready, 32'h0);
        chk("async_hit1", 32'(hit1), 32'h0);
        chk("async_hit2", 32'(hit2), 32'h0);
        chk("async_tag1", 32'(tag_out1), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Dispatch disabled with a nonzero count writes nothing.
        vi = 101;
        dispatch_en = 0; rob_dispatch_num = 3; rob_tail_in = 7;
        dest_reg_idx_in = {5'd1, 5'd1, 5'd1};
        source_reg_idx_in1 = {5'd0, 5'd1, 5'd0};
        source_reg_idx_in2 = '0;
        #1;
        chk("noen_bypass", 32'(hit1), 32'h0);
        @(negedge clk);
        rob_dispatch_num = 0;
        source_reg_idx_in1 = {5'd0, 5'd0, 5'd1};
        #1;
        chk("noen_hit", 32'(hit1), 32'h0);
        chk("noen_cr", check_ready, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/map_table.md
# map_table

Register-rename map table for a 3-wide P6-style out-of-order core. It sits between dispatch and the reservation stations/ROB. At dispatch it translates each source architectural register into the ROB tag of its newest in-flight producer, or reports a miss so the operand is read from the RRF/ROB. It records the ROB tags allocated to up to three destination registers per cycle, and sets per-register ready ("+") bits when tags complete on the CDB.

## Interface
- SIZE, 32: number of architectural registers; index width RW = $clog2(SIZE).
- ROB_SIZE, 32: ROB entries, power of two; tag width TW = $clog2(ROB_SIZE).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset: asserted when 0, clears all state immediately.
- dispatch_en  in  1  qualifies the dispatch write.
- source_reg_idx_in1  in  [2:0][RW-1:0]  rs1 of slot 0..2.
- source_reg_idx_in2  in  [2:0][RW-1:0]  rs2 of slot 0..2.
- dest_reg_idx_in  in  [2:0][RW-1:0]  rd of slot 0..2.
- rob_dispatch_num  in  2  number of dispatched instructions (0–3); slots 0..num-1 are valid.
- rob_tail_in  in  TW  ROB tag of the last entry allocated this cycle.
- complete_en  in  1  qualifies the CDB broadcast.
- CDB_tag_in  in  [2:0][TW-1:0]  completing ROB tags.
- rob_complete_num  in  2  number of valid CDB slots (0–3); slots 0..num-1 are valid.
- tag_out1 / tag_out2  out  [2:0][TW-1:0]  producer tag for rs1/rs2 of each slot.
- ready_out1 / ready_out2  out  [2:0]  producer has completed (+).
- hit1 / hit2  out  [2:0]  mapping valid; when 0, tag_out and ready_out are 0 and the RS reads the RRF.
- check_ready  out  SIZE  per-register ready bits, visible for debug and verification.

## Operation
- State per register r: valid[r], tag[r] (TW bits), ready[r]. All are 0 on reset.
- Register 0 is never renamed. Writes to r0 are ignored, and lookups of r0 always miss.
- Tag allocation: the tag for slot i = (rob_tail_in − rob_dispatch_num + 1 + i) mod ROB_SIZE, for i < rob_dispatch_num.
  - Example: tail 5, num 2 gives slot0 = 4 and slot1 = 5.
  - Wrap: tail 0, num 2 gives slot0 = ROB_SIZE−1 and slot1 = 0.
- Dispatch write: at the clock edge, if dispatch_en, each valid slot i sets valid = 1, tag = slot tag, and ready = 0 for its rd.
  - If several valid slots target the same rd, the highest-numbered slot wins.
- Lookup (combinational):
  - Each source reads the registered table, giving {hit = valid, tag, ready}.
  - Intra-group bypass: if dispatch_en and a lower-numbered valid slot j < i in the same cycle writes the source register, the youngest such j supplies hit = 1, tag = slot-j tag, ready = 0.
  - A slot's own rd never bypasses to its own sources.
- Complete: at the clock edge, if complete_en, every register with valid = 1 whose tag equals any valid CDB_tag_in slot gets ready = 1.
- Dispatch and complete on the same register in the same cycle: the dispatch write wins (new tag, ready = 0).
- Entries are cleared only by reset; there is no retire or flush port in this block.
- check_ready[r] = ready[r] & valid[r].
- rob_dispatch_num or rob_complete_num = 0 is a no-op even when the corresponding enable is 1.

## Timing
- Lookups are combinational within the same cycle.
- Writes and ready updates are visible on outputs the cycle after the edge that captures them (1-cycle latency).
- Reset is asynchronous assert; deassertion is synchronous to clk. All outputs driven from state are 0 while reset is asserted.
- There is no handshake: the enables are sampled every rising edge.

## Configuration
- MAP_TABLE_CDB_BYPASS_EN defined: a source lookup that hits (from the table, not the intra-group bypass) with a tag matching a valid CDB slot this cycle under complete_en reports ready_out = 1 in the same cycle.
- Not defined: ready_out reflects only the registered ready bit, so it rises one cycle after completion.

## Test plan
- Reset, then all sources = r0/r1/r2 with dispatch disabled -> hit1 = hit2 = 000 and check_ready = 0.
- Dispatch rd = {r1, r2, r3}, num = 2, tail = 5, then on the next cycle look up slot0 rs1 = r1, rs2 = r2 -> hit = 1, tags 4 and 5, ready = 0; r0 lookups in slots 1 and 2 miss; r3 stays unmapped.
- Complete with num = 1, CDB_tag_in[0] = 5 -> next cycle check_ready[2] = 1 and check_ready[1] = 0; a lookup of r2 gives ready_out = 1.
- Same-cycle dispatch of slot0 rd = r4 and slot1 rs1 = r4, tail = 9, num = 2 -> slot1 hit = 1, tag = 8, ready = 0.
- Dispatch and complete on the same register in one cycle (r2 remapped while tag 5 completes) -> the new tag is held and ready[2] = 0.
- Tail wrap: tail = 0, num = 3, rd = {r5, r6, r7} -> tags ROB_SIZE−2, ROB_SIZE−1, 0.
